// File: rtl/dmem_access_unit_if.sv
// Request/acknowledge bus between dmem_access_unit (master) and a variable-latency data memory (slave).
interface dmem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store sequencer: req/ack handshake with data memory, lane steering, stall and timeout.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned requests into a trap instead of a memory access.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [2:0]                 funct3,
  input  logic [31:0]                addr,
  input  logic [31:0]                store_data,
  output logic                       stall,
  output logic                       access_done,
  output logic                       load_valid,
  output logic [31:0]                load_word,
  output logic [1:0]                 byte_index,
  output logic [2:0]                 load_funct3,
  output logic                       bus_error,
  output logic                       misalign_trap,
  dmem_access_unit_if.master         dmem
);

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] count_r;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   lane_be = 4'b0001 << offset;
      2'b01:   lane_be = offset[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   lane_data = {4{data[7:0]}};
      2'b01:   lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

  // Stall is combinational in IDLE so the requesting instruction freezes in its own cycle.
  always_comb begin
    stall = 1'b0;
    case (state_r)
      IDLE:    stall = mem_read | mem_write;
      ACCESS:  stall = 1'b1;
      RESP:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Access sequencer with registered handshake, result pulses and captured request fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= IDLE;
      count_r         <= 8'd0;
      access_done     <= 1'b0;
      load_valid      <= 1'b0;
      load_word       <= 32'd0;
      byte_index      <= 2'b00;
      load_funct3     <= 3'b000;
      bus_error       <= 1'b0;
      misalign_trap   <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_be    <= 4'b0000;
      dmem.dmem_wdata <= 32'd0;
    end else begin
      access_done   <= 1'b0;
      load_valid    <= 1'b0;
      bus_error     <= 1'b0;
      misalign_trap <= 1'b0;
      case (state_r)
        IDLE: begin
          count_r <= 8'd0;
          if (mem_read | mem_write) begin
            byte_index      <= addr[1:0];
            load_funct3     <= funct3;
            dmem.dmem_we    <= mem_write;
            dmem.dmem_addr  <= {addr[31:2], 2'b00};
            dmem.dmem_be    <= mem_write ? lane_be(funct3[1:0], addr[1:0]) : 4'b1111;
            dmem.dmem_wdata <= mem_write ? lane_data(funct3[1:0], store_data) : 32'd0;
            if (TRAP_EN && is_misaligned(funct3[1:0], addr[1:0])) begin
              state_r       <= RESP;
              access_done   <= 1'b1;
              misalign_trap <= 1'b1;
            end else begin
              state_r       <= ACCESS;
              dmem.dmem_req <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            access_done   <= 1'b1;
            count_r       <= 8'd0;
            state_r       <= RESP;
            if (!dmem.dmem_we) begin
              load_word  <= dmem.dmem_rdata;
              load_valid <= 1'b1;
            end
          end else if (count_r == LAST_COUNT) begin
            // Memory never answered: abandon the access and report a bus error.
            dmem.dmem_req <= 1'b0;
            access_done   <= 1'b1;
            bus_error     <= 1'b1;
            load_word     <= 32'd0;
            count_r       <= 8'd0;
            state_r       <= RESP;
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        RESP: begin
          count_r <= 8'd0;
          state_r <= IDLE;
        end
        default: begin
          count_r       <= 8'd0;
          dmem.dmem_req <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store access sequencer directly upstream of the load-data extractor in the MEM stage.
- Takes the pipeline's memory request (read/write, funct3, byte address, store data) and runs a req/ack handshake with a variable-latency data memory.
- Generates word-aligned address, byte enables and lane-replicated store data.
- Returns the raw aligned read word plus byte_index and funct3 for sign/zero extension downstream, and stalls the pipeline while the access is in flight.

Parameters:
- TIMEOUT, 64: max ACCESS cycles without dmem_ack before the access is aborted as a bus error. Legal range 1..255.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- mem_read  in  1  load request from MEM stage
- mem_write  in  1  store request from MEM stage
- funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW encodings)
- addr  in  32  byte address
- store_data  in  32  store operand, data in low bits
- stall  out  1  freeze upstream pipeline
- access_done  out  1  one-cycle pulse: access finished (load or store)
- load_valid  out  1  one-cycle pulse: load_word valid
- load_word  out  32  raw aligned memory word (DMemOut for extractor)
- byte_index  out  2  captured addr[1:0]
- load_funct3  out  3  captured funct3 (mem_select for extractor)
- bus_error  out  1  one-cycle pulse: access timed out
- misalign_trap  out  1  one-cycle pulse: misaligned access (see Optional Feature)
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write enable
- dmem_addr  out  32  {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  memory accepted/completed access; rdata valid same cycle for reads
- dmem_rdata  in  32  read data

Behaviour:
- Reset (clock edge with reset=1): state IDLE, timeout counter 0, all outputs 0. Reset during ACCESS drops dmem_req at that edge; no access_done is generated.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - stall = mem_read|mem_write (combinational).
  - On a request, register addr, funct3, store_data and the write flag, then go to ACCESS.
  - mem_read and mem_write both high: treated as a write.
- ACCESS:
  - dmem_req=1; dmem_we/addr/be/wdata stable; stall=1.
  - dmem_ack=1: for reads, latch dmem_rdata into load_word. Go to RESP.
  - No ack: counter++. When counter reaches TIMEOUT-1 without ack, drop req, set bus_error for RESP, load_word=0.
  - Ack in the first ACCESS cycle is legal. Minimum latency is 3 cycles: request seen, ack, RESP.
- RESP:
  - stall=0; access_done=1; load_valid=1 only for successful reads; bus_error=1 if timed out.
  - Request inputs in this cycle belong to the finishing instruction and are ignored. RESP always goes to IDLE; counter cleared.
- load_word, byte_index and load_funct3 hold their values until the next captured access.
- Byte enables and write data:
  - SB: be=4'b0001<<addr[1:0]; wdata={4{store_data[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011; wdata={2{store_data[15:0]}}.
  - SW: be=4'b1111; wdata=store_data.
  - Reads: be=4'b1111, we=0.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request issues no memory access; IDLE goes straight to RESP with stall=1 for the IDLE cycle.
  - In RESP: misalign_trap=1, access_done=1, load_valid=0, bus_error=0.
- Undefined:
  - misalign_trap is tied 0.
  - Misaligned accesses proceed using the alignment-forced lanes: halfword uses addr[1] only, word uses be=1111.
  - byte_index is still the raw addr[1:0].

Test Plan:
- LW addr=0x100, ack in 1st ACCESS cycle, rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, we=0. RESP: load_valid=1, load_word=0xDEADBEEF, byte_index=0. Stall high exactly 2 cycles.
- SB addr=0x203, store_data=0x000000A5, ack after 3 waits -> be=1000, wdata=0xA5A5A5A5, we=1, req held 4 cycles. access_done=1, load_valid=0.
- SH addr=0x302, data=0x1234 -> be=1100, wdata=0x12341234. LHU addr=0x302 -> load_funct3=LHU, byte_index=2.
- LW with dmem_ack never asserted, TIMEOUT=4 -> req high 4 cycles, then RESP with bus_error=1, load_word=0, load_valid=0, FSM back to IDLE.
- LW addr=0x101: with DMEM_MISALIGN_TRAP_EN -> no dmem_req, misalign_trap pulse. Without it -> dmem_addr=0x100, be=1111, byte_index=1, no trap.
- Reset asserted during ACCESS wait -> next cycle dmem_req=0, stall=0, no access_done. Following LW completes normally.
